rng_bank: RTL and testbench
===========================

Name: rng_bank

Overview:
- Parametrised multi-channel successor to the two-channel LFSR random source: NUM_CH independent 32-bit Galois LFSRs, each seeded from one shared 32-bit seed.
- Adds runtime reseed through a valid/ready handshake and a discarded warm-up run after every load.
- Output is one registered word bundle behind a valid/ready handshake, so consumers can stall without losing or duplicating words.
- Used by stimulus and noise generators that need more than two decorrelated streams.

Parameters:
- NUM_CH, 4, number of LFSR channels (1..16).
- OUTPUT_WIDTH, 8, bits per channel output word (1..32).
- WARMUP, 64, LFSR steps discarded after each load (0..1023).
- SEED_DEFAULT, 32'hACE1_2025, seed loaded after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed  in  32  reseed value; sampled when seed_valid && seed_ready.
- seed_valid  in  1  reseed request.
- seed_ready  out  1  high when a reseed is accepted this cycle.
- rnd  out  NUM_CH*OUTPUT_WIDTH  channel i occupies bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- out_valid  out  1  rnd holds an unconsumed word.
- out_ready  in  1  consumer accepts rnd when out_valid && out_ready.

Behaviour:
- LFSR step: next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 0), with LFSR_POLY = 32'h8020_0003 (x^32+x^22+x^2+x+1).
- Channel seed: ch_seed[i] = seed ^ (CH_SALT * i) mod 2^32, with CH_SALT = 32'h9E37_79B9. A zero result is replaced by 32'h0000_0001, so no LFSR ever sits at zero.
- States:
  - LOAD: load every channel with ch_seed, clear the warm-up counter and out_valid; go to WARMUP if WARMUP>0, else RUN. Lasts one cycle.
  - WARMUP: all LFSRs step every cycle; counter increments; go to RUN on the cycle the WARMUP-th step completes.
  - RUN: advance = !out_valid || out_ready. On advance: rnd[i] <= state_i[OUTPUT_WIDTH-1:0] (pre-step value), out_valid <= 1, all LFSRs step. Otherwise hold rnd and state.
- Reset (reset==0, asynchronous, any time including mid-warm-up or mid-stall):
  - rnd=0, out_valid=0, seed_ready=0, counter=0, state=LOAD.
  - LFSR registers = 0, overwritten with the SEED_DEFAULT derivation in LOAD on the first clock after release.
- seed_ready is 1 in WARMUP and RUN, 0 in LOAD. An accepted reseed goes to LOAD next cycle.
- Reseed in RUN with a word pending: out_valid drops to 0 in LOAD; the pending word is discarded, not delivered. A simultaneous out_ready in the accept cycle still counts as a completed transfer of the current word.
- Reseed accepted during WARMUP restarts warm-up from 0.
- Latency:
  - Reset release to first out_valid: 1 (LOAD) + WARMUP + 1 cycles.
  - With sustained out_ready, one new bundle per cycle.
- Once out_valid is high, it never falls except through reset or reseed. rnd is stable while out_valid && !out_ready.

Decomposition:
- Package rng_pkg: LFSR_POLY, CH_SALT, enum rng_state_t {LOAD, WARMUP, RUN}, function lfsr_step(logic [31:0]), function derive_seed(logic [31:0] seed, int ch).
- Sub-module lfsr32_ch: one channel with load, step-enable and a 32-bit state output; instantiated NUM_CH times in a generate loop.
- The top level holds the FSM, warm-up counter and output register.

Test Plan:
- WARMUP=0, SEED_DEFAULT=1, NUM_CH=1, OUTPUT_WIDTH=8, out_ready=1 -> after reset release, out_valid rises on cycle 2; rnd sequence 0x01, 0x03, 0x02 (states 0x1, 0x80200003, 0xC0300002).
- Same config, out_ready=0 for 5 cycles after first valid -> rnd holds 0x01 and LFSR does not step; on release the next word is 0x03.
- seed=0, NUM_CH=2, WARMUP=0 -> ch0 state loads 0x00000001, ch1 loads 0x9E3779B9; first bundle rnd = {0xB9, 0x01}.
- WARMUP=64, default seed -> out_valid low for exactly 65 cycles after release; first word equals the reference-model state after 64 steps.
- Reseed 32'h1 during a stall with out_valid=1 -> seed_ready=1 in the accept cycle, out_valid=0 next cycle, the pending word is never delivered, and the output restarts from the seed-1 sequence.
- Assert reset for one half-cycle mid-RUN -> outputs clear immediately without a clock edge; after release the sequence repeats the SEED_DEFAULT stream from its first word.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the multi-channel LFSR random source.
//   LFSR_POLY   : Galois feedback taps (x^32+x^22+x^2+x+1)
//   CH_SALT     : per-channel multiplier used to decorrelate channel seeds
//   rng_state_t : controller states
//   lfsr_step   : one Galois step of a 32-bit state
//   derive_seed : channel seed from the shared seed, never zero
package rng_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] CH_SALT   = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } rng_state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] derive_seed(input logic [31:0] seed, input int ch);
        logic [31:0] mixed;
        mixed = seed ^ 32'(CH_SALT * 32'(ch));
        return (mixed == 32'h0) ? 32'h1 : mixed;
    endfunction

endpackage

// File: rtl/lfsr32_ch.sv
// One 32-bit Galois LFSR channel.
//   clk, reset : clock, async active-low reset (state clears to 0)
//   load       : load load_value this cycle (has priority over step)
//   load_value : value loaded on load
//   step       : advance the LFSR by one step
//   state      : current 32-bit LFSR state
module lfsr32_ch
    import rng_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else if (load) begin
            state <= load_value;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/rng_bank.sv
// Bank of NUM_CH independent LFSRs seeded from one shared seed, with a
// warm-up run after each load and a valid/ready output bundle.
//   clk, reset  : clock, async active-low reset
//   seed        : reseed value, taken when seed_valid && seed_ready
//   seed_valid  : reseed request
//   seed_ready  : high in WARMUP and RUN
//   rnd         : channel i in bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   out_valid   : rnd holds an unconsumed bundle
//   out_ready   : consumer takes rnd when out_valid && out_ready
module rng_bank
    import rng_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned OUTPUT_WIDTH = 8,
    parameter int unsigned WARMUP       = 64,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2025
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    seed,
    input  logic                           seed_valid,
    output logic                           seed_ready,
    output logic [NUM_CH*OUTPUT_WIDTH-1:0] rnd,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned RND_W = NUM_CH * OUTPUT_WIDTH;
    localparam int unsigned CNT_W = 11;
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP - 1);

    rng_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        seed_reg;
    logic [31:0]        ch_state [NUM_CH];
    logic [RND_W-1:0]   rnd_next_c;
    logic               accept_c;
    logic               advance_c;
    logic               load_c;
    logic               step_c;

    assign accept_c  = seed_valid && seed_ready;
    assign advance_c = !out_valid || out_ready;
    assign load_c    = (state == rng_pkg::LOAD);
    // A step during the reseed-accept cycle is harmless: LOAD reloads next.
    assign step_c    = (state == rng_pkg::WARMUP) ||
                       ((state == rng_pkg::RUN) && advance_c);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lfsr32_ch u_ch (
            .clk        (clk),
            .reset      (reset),
            .load       (load_c),
            .load_value (derive_seed(seed_reg, i)),
            .step       (step_c),
            .state      (ch_state[i])
        );
    end

    // Output word is the low slice of each channel's pre-step state.
    always_comb begin
        rnd_next_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rnd_next_c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = ch_state[i][OUTPUT_WIDTH-1:0];
        end
    end

    // Controller: load / warm-up / run, plus output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= rng_pkg::LOAD;
            cnt        <= '0;
            seed_reg   <= SEED_DEFAULT;
            seed_ready <= 1'b0;
            out_valid  <= 1'b0;
            rnd        <= '0;
        end else if (accept_c) begin
            // Pending word is dropped; a same-cycle out_ready still completed it.
            state      <= rng_pkg::LOAD;
            seed_reg   <= seed;
            seed_ready <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                rng_pkg::LOAD: begin
                    cnt        <= '0;
                    out_valid  <= 1'b0;
                    seed_ready <= 1'b1;
                    if (WARMUP == 0) begin
                        state <= rng_pkg::RUN;
                    end else begin
                        state <= rng_pkg::WARMUP;
                    end
                end
                rng_pkg::WARMUP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == WARMUP_LAST) begin
                        state <= rng_pkg::RUN;
                    end
                end
                rng_pkg::RUN: begin
                    if (advance_c) begin
                        rnd       <= rnd_next_c;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= rng_pkg::LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_bank.sv
// Scoreboard bench for rng_bank: two instances (A: 2 ch, no warm-up, seed 1;
// B: defaults, 64-step warm-up) checked against a plain-arithmetic model.
module tb_rng_bank;

    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [31:0] SALT = 32'h9E37_79B9;
    localparam int          A_CH = 2;
    localparam int          A_OW = 8;
    localparam int          A_WU = 0;
    localparam logic [31:0] A_SEED = 32'h0000_0001;
    localparam int          B_CH = 4;
    localparam int          B_OW = 8;
    localparam int          B_WU = 64;
    localparam logic [31:0] B_SEED = 32'hACE1_2025;
    localparam int          QN = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed_a, seed_b;
    logic        sv_a, sv_b, sr_a, sr_b;
    logic        ov_a, ov_b, or_a, or_b;
    logic [15:0] rnd_a;
    logic [31:0] rnd_b;

    logic [127:0] q_a[$];
    logic [127:0] q_b[$];
    int tests = 0;
    int fails = 0;
    int rst_epoch = 0;
    int words_a = 0;
    int words_b = 0;

    always #5 clk = ~clk;

    rng_bank #(.NUM_CH(A_CH), .OUTPUT_WIDTH(A_OW), .WARMUP(A_WU), .SEED_DEFAULT(A_SEED)) u_a (
        .clk(clk), .reset(rst_n), .seed(seed_a), .seed_valid(sv_a), .seed_ready(sr_a),
        .rnd(rnd_a), .out_valid(ov_a), .out_ready(or_a)
    );

    rng_bank #(.NUM_CH(B_CH), .OUTPUT_WIDTH(B_OW), .WARMUP(B_WU), .SEED_DEFAULT(B_SEED)) u_b (
        .clk(clk), .reset(rst_n), .seed(seed_b), .seed_valid(sv_b), .seed_ready(sr_b),
        .rnd(rnd_b), .out_valid(ov_b), .out_ready(or_b)
    );

    function automatic logic [31:0] model_next(input logic [31:0] s);
        return (s >> 1) ^ ((s % 2 == 1) ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] model_seed(input logic [31:0] s, input int ch);
        logic [31:0] v;
        v = s ^ 32'(SALT * 32'(ch));
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Refill the expected stream for one instance after a (re)load.
    task automatic load_model(input int which, input logic [31:0] s);
        logic [31:0]  st [16];
        logic [127:0] w;
        int nch, ow, wu;
        nch = (which == 0) ? A_CH : B_CH;
        ow  = (which == 0) ? A_OW : B_OW;
        wu  = (which == 0) ? A_WU : B_WU;
        for (int c = 0; c < nch; c++) begin
            st[c] = model_seed(s, c);
            for (int k = 0; k < wu; k++) st[c] = model_next(st[c]);
        end
        if (which == 0) q_a.delete(); else q_b.delete();
        for (int n = 0; n < QN; n++) begin
            w = '0;
            for (int c = 0; c < nch; c++) begin
                w = w | (128'(64'(st[c]) % (64'd1 << ow)) << (c * ow));
                st[c] = model_next(st[c]);
            end
            if (which == 0) q_a.push_back(w); else q_b.push_back(w);
        end
    endtask

    // Monitor A: pops on each transfer, checks stall stability.
    logic [15:0] hold_a;
    logic        stall_a = 1'b0;
    logic        acc_a = 1'b0;
    int          epoch_a = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_a && !acc_a && epoch_a == rst_epoch) begin
                check("a_stall_valid", 128'(ov_a), 128'(1));
                if (ov_a) check("a_stall_hold", 128'(rnd_a), 128'(hold_a));
            end
            if (ov_a && or_a) begin
                words_a++;
                if (q_a.size() == 0) check("a_queue_empty", 128'(1), 128'(0));
                else check("a_word", 128'(rnd_a), q_a.pop_front());
            end
            stall_a = ov_a && !or_a;
            hold_a  = rnd_a;
            acc_a   = sv_a && sr_a;
            epoch_a = rst_epoch;
        end else begin
            stall_a = 1'b0;
        end
    end

    // Monitor B.
    logic [31:0] hold_b;
    logic        stall_b = 1'b0;
    logic        acc_b = 1'b0;
    int          epoch_b = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_b && !acc_b && epoch_b == rst_epoch) begin
                check("b_stall_valid", 128'(ov_b), 128'(1));
                if (ov_b) check("b_stall_hold", 128'(rnd_b), 128'(hold_b));
            end
            if (ov_b && or_b) begin
                words_b++;
                if (q_b.size() == 0) check("b_queue_empty", 128'(1), 128'(0));
                else check("b_word", 128'(rnd_b), q_b.pop_front());
            end
            stall_b = ov_b && !or_b;
            hold_b  = rnd_b;
            acc_b   = sv_b && sr_b;
            epoch_b = rst_epoch;
        end else begin
            stall_b = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            or_a = 1'($urandom_range(0, 1));
            or_b = 1'($urandom_range(0, 1));
        end
    endtask

    // Counts edges until out_valid rises; called just after a reference edge.
    task automatic expect_first_valid(input int which, input int edges, input string name);
        int seen;
        seen = -1;
        for (int e = 1; e <= edges + 20; e++) begin
            step();
            if ((which == 0) ? ov_a : ov_b) begin
                seen = e;
                break;
            end
        end
        check(name, 128'(seen), 128'(edges));
    endtask

    task automatic reseed(input int which, input logic [31:0] s);
        logic got;
        got = 1'b0;
        if (which == 0) begin seed_a = s; sv_a = 1'b1; end
        else begin seed_b = s; sv_b = 1'b1; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (which == 0) ? sr_a : sr_b;
        end
        check("seed_ready_wait", 128'(got), 128'(1));
        step();
        if (which == 0) sv_a = 1'b0; else sv_b = 1'b0;
        load_model(which, s);
        check("reseed_drop", 128'((which == 0) ? ov_a : ov_b), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        seed_a = '0; seed_b = '0;
        sv_a = 1'b0; sv_b = 1'b0;
        or_a = 1'b1; or_b = 1'b1;
        repeat (2) step();
        check("rst_a_rnd", 128'(rnd_a), 128'(0));
        check("rst_a_valid", 128'(ov_a), 128'(0));
        check("rst_a_ready", 128'(sr_a), 128'(0));
        check("rst_b_rnd", 128'(rnd_b), 128'(0));
        check("rst_b_valid", 128'(ov_b), 128'(0));
        load_model(0, A_SEED);
        load_model(1, B_SEED);
        #2 rst_n = 1'b1;

        // Edge 1: LOAD done.
        step();
        check("a_load_valid", 128'(ov_a), 128'(0));
        check("a_seed_ready", 128'(sr_a), 128'(1));
        check("b_seed_ready", 128'(sr_b), 128'(1));
        // Edge 2: first A bundle {0xB8, 0x01}; then 0xDC03, 0x6E02.
        step();
        check("a_first_valid", 128'(ov_a), 128'(1));
        check("a_word0", 128'(rnd_a), 128'(16'hB801));
        step();
        check("a_word1", 128'(rnd_a), 128'(16'hDC03));
        step();
        check("a_word2", 128'(rnd_a), 128'(16'h6E02));
        // Stall A for 5 cycles.
        or_a = 1'b0;
        repeat (5) step();
        check("a_stall_word", 128'(rnd_a), 128'(16'h6E02));
        or_a = 1'b1;
        // 9 edges used so far; B first valid on edge 66.
        expect_first_valid(1, 57, "b_latency");

        // Reseed A with 0 while a word is pending under stall.
        or_a = 1'b0;
        step();
        reseed(0, 32'h0);
        step();
        check("a_reseed_run_valid", 128'(ov_a), 128'(0));
        step();
        check("a_reseed_valid", 128'(ov_a), 128'(1));
        check("a_seed0_word", 128'(rnd_a), 128'(16'hB901));
        or_a = 1'b1;
        run_cycles(10);

        // Randomized reseeds with random back-pressure.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) == 0) reseed(1, $urandom);
            else reseed(0, $urandom);
            run_cycles($urandom_range(3, 30));
        end

        // Reseed B mid-warm-up: warm-up restarts from zero.
        reseed(1, $urandom);
        run_cycles(10);
        reseed(1, $urandom);
        expect_first_valid(1, 66, "b_rewarm_latency");
        or_a = 1'b1; or_b = 1'b1;
        run_cycles(20);
        or_a = 1'b1; or_b = 1'b1;
        step();

        // Asynchronous reset pulse between clock edges.
        #1 rst_n = 1'b0;
        rst_epoch++;
        #1;
        check("arst_a_valid", 128'(ov_a), 128'(0));
        check("arst_a_rnd", 128'(rnd_a), 128'(0));
        check("arst_a_ready", 128'(sr_a), 128'(0));
        check("arst_b_valid", 128'(ov_b), 128'(0));
        check("arst_b_rnd", 128'(rnd_b), 128'(0));
        check("arst_b_ready", 128'(sr_b), 128'(0));
        load_model(0, A_SEED);
        load_model(1, B_SEED);
        or_a = 1'b1; or_b = 1'b1;
        #1 rst_n = 1'b1;
        step();
        check("a_rerun_load", 128'(ov_a), 128'(0));
        step();
        check("a_rerun_word0", 128'(rnd_a), 128'(16'hB801));
        expect_first_valid(1, 64, "b_reset_latency");
        run_cycles(20);

        check("a_words_seen", 128'(words_a > 50), 128'(1));
        check("b_words_seen", 128'(words_b > 10), 128'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
